// File: rtl/poly_reduce_round_64_pkg.sv
// Shared poly package: FSM state encoding, coefficient count, rounding
// shift and the product-RAM address offset of the high half.
package poly_reduce_round_64_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } poly_state_t;

    localparam int POLY_N_COEFF     = 64;
    localparam int POLY_SHIFT       = 3;
    localparam int POLY_ADDR_OFFSET = 64;
    localparam int ADDR_WIDTH       = 7;
    localparam int IDX_WIDTH        = 6;

    // High-half address that pairs with a low-half address (x^64 partner).
    function automatic logic [ADDR_WIDTH-1:0] hi_addr(input logic [ADDR_WIDTH-1:0] lo);
        return lo + ADDR_WIDTH'(POLY_ADDR_OFFSET);
    endfunction

endpackage

// File: rtl/poly_skid_fifo2.sv
// Two-entry FIFO with the head always presented on head_data; the upstream
// issue gating keeps it from ever being pushed while full.
module poly_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop_ok;

    assign pop_ok     = pop && (count != 2'd0);
    assign head_data  = slot0;
    assign head_valid = (count != 2'd0);

    // Slot 0 is the head; simultaneous push/pop shifts and refills in one edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= push_data;
                        count <= 2'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/poly_reduce_round_64.sv
// Negacyclic fold and rounding of a 128-word product RAM into 64 output
// coefficients, streamed over a valid/ready port through a 2-entry FIFO.
module poly_reduce_round_64
    import poly_reduce_round_64_pkg::*;
#(
    parameter int N_COEFF     = POLY_N_COEFF,
    parameter int COEFF_WIDTH = 16,
    parameter int SHIFT       = POLY_SHIFT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [COEFF_WIDTH-1:0]     h,
    output logic [ADDR_WIDTH-1:0]      addrLo,
    output logic [ADDR_WIDTH-1:0]      addrHi,
    input  logic [COEFF_WIDTH-1:0]     dataLo,
    input  logic [COEFF_WIDTH-1:0]     dataHi,
    output logic [COEFF_WIDTH-SHIFT-1:0] out_data,
    output logic [IDX_WIDTH-1:0]       out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int OUT_WIDTH  = COEFF_WIDTH - SHIFT;
    localparam int FIFO_WIDTH = OUT_WIDTH + IDX_WIDTH;

    poly_state_t             state;
    logic [ADDR_WIDTH-1:0]   i;
    logic [ADDR_WIDTH-1:0]   addr_hold;
    logic [COEFF_WIDTH-1:0]  h_reg;
    logic                    rd_valid;
    logic [IDX_WIDTH-1:0]    rd_index;
    logic                    issue;
    logic                    pop;
    logic [1:0]              fifo_count;
    logic [1:0]              occ_after_pop;
    logic [COEFF_WIDTH-1:0]  diff;
    logic [COEFF_WIDTH-1:0]  sum;
    logic [OUT_WIDTH-1:0]    rounded;
    logic [FIFO_WIDTH-1:0]   head;
    logic                    head_valid;

    // Issue a read only if the FIFO (after this cycle's pop) plus the read
    // already in flight leaves room for it when its data arrives.
    always_comb begin
        pop           = head_valid && out_ready;
        occ_after_pop = fifo_count - {1'b0, pop};
        issue         = (state == RUN) &&
                        (({1'b0, occ_after_pop} + {2'b0, rd_valid}) < 3'd2);
    end

    assign addrLo = issue ? i : addr_hold;
    assign addrHi = hi_addr(addrLo);

    // Fold x^64 = -1 as a subtraction, add the rounding constant, drop SHIFT bits.
    always_comb begin
        diff    = dataLo - dataHi;
        sum     = diff + h_reg;
        rounded = OUT_WIDTH'(sum >> SHIFT);
    end

    poly_skid_fifo2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (rd_valid),
        .push_data  ({rounded, rd_index}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign out_valid = head_valid;
    assign out_data  = head[FIFO_WIDTH-1:IDX_WIDTH];
    assign out_index = head[IDX_WIDTH-1:0];

    // Control FSM with the read pipeline stage and registered busy/done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            i         <= '0;
            addr_hold <= '0;
            h_reg     <= '0;
            rd_valid  <= 1'b0;
            rd_index  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                addr_hold <= i;
                rd_index  <= i[IDX_WIDTH-1:0];
                i         <= i + ADDR_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        h_reg <= h;
                        i     <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && (i == ADDR_WIDTH'(N_COEFF - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rd_valid && (occ_after_pop == 2'd0)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
